// File: rtl/neuron_seq_pkg.sv
// Shared types and constants for the neuron phase sequencer.
// Covers the state encoding, command op codes and the {FP,BP} phase codes.
package neuron_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_F_SETUP = 3'd1,
    S_F_RUN   = 3'd2,
    S_F_DONE  = 3'd3,
    S_B_SETUP = 3'd4,
    S_B_RUN   = 3'd5,
    S_B_DONE  = 3'd6
  } seq_state_e;

  localparam logic [1:0] OP_FWD   = 2'b00;
  localparam logic [1:0] OP_BWD   = 2'b01;
  localparam logic [1:0] OP_TRAIN = 2'b10;

  localparam logic [1:0] PH_FSETUP = 2'b00;
  localparam logic [1:0] PH_FWD    = 2'b10;
  localparam logic [1:0] PH_BWD    = 2'b01;
  localparam logic [1:0] PH_BSETUP = 2'b11;

  // 00 is the only code that leaves y and W_out untouched, so every hold state maps to it.
  function automatic logic [1:0] phase_of(input seq_state_e st);
    logic [1:0] code;
    case (st)
      S_F_RUN:   code = PH_FWD;
      S_B_SETUP: code = PH_BSETUP;
      S_B_RUN:   code = PH_BWD;
      default:   code = PH_FSETUP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/neuron_phase_sequencer_phase_timer.sv
// Loadable down-counter that times the forward and backward RUN phases.
// o_expired is high whenever the count is zero; the count parks at zero.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_count;

  // Load takes priority over counting; the counter holds once it reaches zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != {CNT_W{1'b0}}) begin
      r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (r_count == {CNT_W{1'b0}});

endmodule

// File: rtl/neuron_phase_sequencer.sv
// Drives the {FP,BP} phase codes of one ReLU neuron for FWD, BWD and TRAIN commands.
// Optional pass counters o_fwd_count/o_bwd_count are built when SEQ_PERF_CNT_EN is defined.
module neuron_phase_sequencer
  import neuron_seq_pkg::*;
#(
  parameter int N         = 6,
  parameter int FP_CYCLES = N / 2 + 4,
  parameter int BP_CYCLES = N + 4,
  parameter int CNT_W     = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  input  logic [1:0]  i_cmd_op,
  output logic        o_cmd_ready,
  output logic        o_cmd_err,
  output logic        o_fp,
  output logic        o_bp,
  output logic        o_busy,
  output logic        o_y_valid,
  output logic        o_w_valid
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] o_fwd_count,
  output logic [31:0] o_bwd_count
`endif
);

  localparam logic [CNT_W-1:0] FP_LOAD = CNT_W'(FP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BP_LOAD = CNT_W'(BP_CYCLES - 1);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic             r_cmd_ready;
  logic             r_cmd_err;
  logic             r_fp;
  logic             r_bp;
  logic             r_busy;
  logic             r_y_valid;
  logic             r_w_valid;
  logic             r_act_ok;
  logic             r_train;
  logic             w_op_ok;
  logic             w_accept;
  logic             w_reject;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_expired;

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_phase_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_tmr_load),
    .i_load_val(w_tmr_val),
    .o_expired (w_tmr_expired)
  );

  // A backward pass needs the pre-activation left behind by an earlier forward pass.
  assign w_op_ok  = (i_cmd_op == OP_FWD) || (i_cmd_op == OP_TRAIN) ||
                    ((i_cmd_op == OP_BWD) && r_act_ok);
  assign w_accept = (r_state == S_IDLE) && i_cmd_valid && w_op_ok;
  assign w_reject = (r_state == S_IDLE) && i_cmd_valid && !w_op_ok;

  // Next-state selection and timer loading on entry to each RUN phase.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = {CNT_W{1'b0}};
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (i_cmd_op == OP_BWD) ? S_B_SETUP : S_F_SETUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_F_SETUP: begin
        w_state_nxt = S_F_RUN;
        w_tmr_load  = 1'b1;
        w_tmr_val   = FP_LOAD;
      end
      S_F_RUN: begin
        if (w_tmr_expired) begin
          w_state_nxt = S_F_DONE;
        end else begin
          w_state_nxt = S_F_RUN;
        end
      end
      S_F_DONE: begin
        if (r_train) begin
          w_state_nxt = S_B_SETUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_B_SETUP: begin
        w_state_nxt = S_B_RUN;
        w_tmr_load  = 1'b1;
        w_tmr_val   = BP_LOAD;
      end
      S_B_RUN: begin
        if (w_tmr_expired) begin
          w_state_nxt = S_B_DONE;
        end else begin
          w_state_nxt = S_B_RUN;
        end
      end
      S_B_DONE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register; every output is registered from the next state so it lines up with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_cmd_err   <= 1'b0;
      r_fp        <= 1'b0;
      r_bp        <= 1'b0;
      r_busy      <= 1'b0;
      r_y_valid   <= 1'b0;
      r_w_valid   <= 1'b0;
      r_act_ok    <= 1'b0;
      r_train     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cmd_ready    <= (w_state_nxt == S_IDLE);
      r_cmd_err      <= w_reject;
      {r_fp, r_bp}   <= phase_of(w_state_nxt);
      r_busy         <= (w_state_nxt != S_IDLE);
      r_y_valid      <= (w_state_nxt == S_F_DONE);
      r_w_valid      <= (w_state_nxt == S_B_DONE);
      r_act_ok       <= r_act_ok || (r_state == S_F_DONE);
      r_train        <= w_accept ? (i_cmd_op == OP_TRAIN) : r_train;
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_cmd_err   = r_cmd_err;
  assign o_fp        = r_fp;
  assign o_bp        = r_bp;
  assign o_busy      = r_busy;
  assign o_y_valid   = r_y_valid;
  assign o_w_valid   = r_w_valid;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_fwd_count;
  logic [31:0] r_bwd_count;

  // Completed-pass counters; they wrap naturally at 2^32.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fwd_count <= 32'd0;
      r_bwd_count <= 32'd0;
    end else begin
      r_fwd_count <= (r_state == S_F_DONE) ? r_fwd_count + 32'd1 : r_fwd_count;
      r_bwd_count <= (r_state == S_B_DONE) ? r_bwd_count + 32'd1 : r_bwd_count;
    end
  end

  assign o_fwd_count = r_fwd_count;
  assign o_bwd_count = r_bwd_count;
`else
  // Counter outputs and state are absent in this build.
`endif

endmodule

// File: tb/tb_neuron_phase_sequencer.sv
// Self-checking bench for neuron_phase_sequencer (N=6: 7 forward, 10 backward RUN cycles).
// Expected per-cycle outputs come from a pass-level trace model; counters checked if SEQ_PERF_CNT_EN.
module tb_neuron_phase_sequencer;

  localparam int FP = 7;
  localparam int BP = 10;

  // Observed/expected vector: {fp, bp, y_valid, w_valid, busy, cmd_ready, cmd_err}
  localparam logic [6:0] V_IDLE   = 7'b00_0_0_0_1_0;
  localparam logic [6:0] V_REJECT = 7'b00_0_0_0_1_1;
  localparam logic [6:0] V_FSETUP = 7'b00_0_0_1_0_0;
  localparam logic [6:0] V_FRUN   = 7'b10_0_0_1_0_0;
  localparam logic [6:0] V_FDONE  = 7'b00_1_0_1_0_0;
  localparam logic [6:0] V_BSETUP = 7'b11_0_0_1_0_0;
  localparam logic [6:0] V_BRUN   = 7'b01_0_0_1_0_0;
  localparam logic [6:0] V_BDONE  = 7'b00_0_1_1_0_0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_ready, cmd_err, fp, bp, busy, y_valid, w_valid;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] fwd_count, bwd_count;
`endif

  int checks = 0;
  int failures = 0;
  bit m_act_ok = 1'b0;
  int m_fwd = 0;
  int m_bwd = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  neuron_phase_sequencer dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cmd_valid(cmd_valid),
    .i_cmd_op   (cmd_op),
    .o_cmd_ready(cmd_ready),
    .o_cmd_err  (cmd_err),
    .o_fp       (fp),
    .o_bp       (bp),
    .o_busy     (busy),
    .o_y_valid  (y_valid),
    .o_w_valid  (w_valid)
`ifdef SEQ_PERF_CNT_EN
    ,
    .o_fwd_count(fwd_count),
    .o_bwd_count(bwd_count)
`endif
  );

  function automatic logic [6:0] obs();
    return {fp, bp, y_valid, w_valid, busy, cmd_ready, cmd_err};
  endfunction

  function automatic bit accepted(input logic [1:0] op);
    return (op == 2'b00) || (op == 2'b10) || (op == 2'b01 && m_act_ok);
  endfunction

  // Model: the cycle-by-cycle outputs that follow an accept edge for one command.
  task automatic build_trace(input logic [1:0] op);
    exp_q.delete();
    if (!accepted(op)) begin
      exp_q.push_back(V_REJECT);
    end else begin
      if (op != 2'b01) begin
        exp_q.push_back(V_FSETUP);
        for (int i = 0; i < FP; i++) exp_q.push_back(V_FRUN);
        exp_q.push_back(V_FDONE);
      end
      if (op != 2'b00) begin
        exp_q.push_back(V_BSETUP);
        for (int i = 0; i < BP; i++) exp_q.push_back(V_BRUN);
        exp_q.push_back(V_BDONE);
      end
    end
  endtask

  task automatic commit_model(input logic [1:0] op);
    if (accepted(op)) begin
      if (op != 2'b01) begin
        m_act_ok = 1'b1;
        m_fwd++;
      end
      if (op != 2'b00) m_bwd++;
    end
  endtask

  task automatic model_reset();
    m_act_ok = 1'b0;
    m_fwd = 0;
    m_bwd = 0;
  endtask

  // Called at a negedge: present op for exactly one rising edge (cycle 0).
  task automatic send(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op = op;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs() !== V_IDLE) begin
        failures++;
        $display("FAIL reset cyc%0d got=%b exp=%b", c, obs(), V_IDLE);
      end
    end
`ifdef SEQ_PERF_CNT_EN
    checks++;
    if (fwd_count !== 32'd0 || bwd_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", fwd_count, bwd_count);
    end
`endif
  endtask

  task automatic test_pass(input string name, input logic [1:0] op);
    build_trace(op);
    send(op);
    foreach (exp_q[i]) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL %s cyc%0d got=%b exp=%b", name, i + 1, obs(), exp_q[i]);
      end
    end
    commit_model(op);
    @(negedge clk);
    checks++;
    if (obs() !== V_IDLE) begin
      failures++;
      $display("FAIL %s_idle cyc%0d got=%b exp=%b", name, exp_q.size() + 1, obs(), V_IDLE);
    end
  endtask

  task automatic test_reset_mid_train();
    build_trace(2'b10);
    send(2'b10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL midrst_pre cyc%0d got=%b exp=%b", i + 1, obs(), exp_q[i]);
      end
    end
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 6; c < 24; c++) begin
      checks++;
      if (obs() !== V_IDLE) begin
        failures++;
        $display("FAIL midrst_idle cyc%0d got=%b exp=%b", c, obs(), V_IDLE);
      end
      @(negedge clk);
    end
    test_pass("bwd_after_rst", 2'b01);
  endtask

  task automatic test_back_to_back();
    build_trace(2'b00);
    send(2'b00);
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    foreach (exp_q[i]) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_fwd cyc%0d got=%b exp=%b", i + 1, obs(), exp_q[i]);
      end
    end
    commit_model(2'b00);
    @(negedge clk);
    checks++;
    if (obs() !== V_IDLE) begin
      failures++;
      $display("FAIL b2b_gap cyc10 got=%b exp=%b", obs(), V_IDLE);
    end
    build_trace(2'b10);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    foreach (exp_q[i]) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_train cyc%0d got=%b exp=%b", i + 11, obs(), exp_q[i]);
      end
    end
    commit_model(2'b10);
    @(negedge clk);
    checks++;
    if (obs() !== V_IDLE) begin
      failures++;
      $display("FAIL b2b_end got=%b exp=%b", obs(), V_IDLE);
    end
`ifdef SEQ_PERF_CNT_EN
    checks++;
    if (fwd_count !== 32'(m_fwd) || bwd_count !== 32'(m_bwd)) begin
      failures++;
      $display("FAIL b2b_counts got=%0d/%0d exp=%0d/%0d", fwd_count, bwd_count, m_fwd, m_bwd);
    end
`endif
  endtask

  task automatic test_random();
    logic [1:0] op;
    int gap;
    for (int n = 0; n < 14; n++) begin
      op = 2'($urandom_range(0, 3));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++;
        if (obs() !== V_IDLE) begin
          failures++;
          $display("FAIL rand_gap n%0d got=%b exp=%b", n, obs(), V_IDLE);
        end
      end
      test_pass($sformatf("rand_op%0d_n%0d", op, n), op);
    end
`ifdef SEQ_PERF_CNT_EN
    checks++;
    if (fwd_count !== 32'(m_fwd) || bwd_count !== 32'(m_bwd)) begin
      failures++;
      $display("FAIL rand_counts got=%0d/%0d exp=%0d/%0d", fwd_count, bwd_count, m_fwd, m_bwd);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_pass("bwd_no_act", 2'b01);
    test_pass("op_reserved", 2'b11);
    test_pass("fwd", 2'b00);
    test_pass("bwd_after_fwd", 2'b01);
    test_pass("train", 2'b10);
    test_reset_mid_train();
    test_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
